// File: rtl/count_arbiter.sv
// Round-robin arbiter in front of a single shared up/down counter.
// A granted requester gets the counter loaded (0 for up, its length for down).
// The counter then steps toward the terminal value and a one-cycle done pulse follows.
// Dropping the request mid-count aborts the transaction without a done pulse.
module count_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_len,
    input  logic [NREQ-1:0]       req_up,
    input  logic                  pause,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic                  busy,
    output logic [WIDTH-1:0]      count_out,
    output logic                  max_count,
    output logic                  zero
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]       r_state;
    logic [IW-1:0]    r_winner;
    logic [IW-1:0]    r_last;
    logic [WIDTH-1:0] r_target;
    logic             r_up;
    logic [WIDTH-1:0] r_count;

    logic [IW-1:0]    w_pick;
    logic [WIDTH-1:0] w_len;
    logic             w_up;
    logic [WIDTH-1:0] w_term;

    // Round-robin pick: the lowest offset after r_last with a pending request wins.
    always_comb begin
        w_pick = r_last;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[IW'((int'(r_last) + k) % NREQ)]) begin
                w_pick = IW'((int'(r_last) + k) % NREQ);
            end
        end
    end

    // Select the length and direction belonging to the pick.
    always_comb begin
        w_len = '0;
        w_up  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == IW'(i)) begin
                w_len = req_len[i*WIDTH +: WIDTH];
                w_up  = req_up[i];
            end
        end
    end

    assign w_term = r_up ? r_target : '0;

    // Arbitration, load, count and completion sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_winner <= '0;
            r_last   <= IW'(NREQ - 1);
            r_target <= '0;
            r_up     <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (|req) begin
                        r_winner <= w_pick;
                        r_target <= w_len;
                        r_up     <= w_up;
                        r_state  <= StLoad;
                    end
                end
                StLoad: begin
                    r_count <= r_up ? '0 : r_target;
                    r_state <= StRun;
                end
                StRun: begin
                    if (!req[r_winner]) begin
                        r_last  <= r_winner;
                        r_state <= StIdle;
                    end else if (r_count == w_term) begin
                        r_state <= StDone;
                    end else if (!pause) begin
                        r_count <= r_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
                    end
                end
                StDone: begin
                    r_last  <= r_winner;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Grant and done are decoded from the held winner index.
    always_comb begin
        busy = (r_state != StIdle);
        gnt  = '0;
        done = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i]  = busy && (r_winner == IW'(i));
            done[i] = (r_state == StDone) && (r_winner == IW'(i));
        end
    end

    assign count_out = r_count;
    assign max_count = &r_count;
    assign zero      = (r_count == '0);

endmodule

// File: tb/tb_count_arbiter.sv
// Bench for count_arbiter: a vector table, directed corner-case sequences,
// and a randomized run checked against a transaction-level model.
module tb_count_arbiter;

    localparam int W = 4;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_len;
    logic [N-1:0]   req_up = '0;
    logic           pause = 1'b0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   count_out;
    logic           max_count;
    logic           zero;

    logic [W-1:0]   lens [N];

    always #5 clk = ~clk;

    always_comb req_len = {lens[3], lens[2], lens[1], lens[0]};

    count_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_len   (req_len),
        .req_up    (req_up),
        .pause     (pause),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .count_out (count_out),
        .max_count (max_count),
        .zero      (zero)
    );

    int total = 0;
    int bad = 0;
    bit use_model = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: owner of the counter, steps taken toward the target.
    int m_owner = -1;
    int m_last = N - 1;
    int m_tgt, m_steps, m_count;
    bit m_up, m_loaded, m_fin;

    function automatic void model_step();
        if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_count = 0; m_fin = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_tgt = int'(lens[m_owner]);
                    m_up = req_up[m_owner];
                    m_loaded = 0; m_fin = 0;
                end
            end
        end else if (m_fin) begin
            m_last = m_owner; m_owner = -1; m_fin = 0;
        end else if (!m_loaded) begin
            m_loaded = 1; m_steps = 0;
            m_count = m_up ? 0 : m_tgt;
        end else if (!req[m_owner]) begin
            m_last = m_owner; m_owner = -1;
        end else if (m_steps == m_tgt) begin
            m_fin = 1;
        end else if (!pause) begin
            m_steps++;
            m_count = m_up ? m_steps : m_tgt - m_steps;
        end
    endfunction

    function automatic logic [N-1:0] exp_onehot(input bit en);
        logic [N-1:0] v = '0;
        if (en && m_owner >= 0) v[m_owner] = 1'b1;
        return v;
    endfunction

    task automatic model_check();
        chk("model.gnt", 32'(gnt), 32'(exp_onehot(1'b1)));
        chk("model.done", 32'(done), 32'(exp_onehot(m_fin)));
        chk("model.busy", 32'(busy), 32'(m_owner >= 0));
        chk("model.count", 32'(count_out), 32'(m_count));
        chk("model.max", 32'(max_count), 32'(m_count == (1 << W) - 1));
        chk("model.zero", 32'(zero), 32'(m_count == 0));
    endtask

    task automatic tick();
        @(posedge clk);
        if (use_model) model_step();
        #1;
        if (use_model) model_check();
    endtask

    task automatic hs_reset();
        rst_n = 1'b0; req = '0; pause = 1'b0; req_up = '0;
        for (int i = 0; i < N; i++) lens[i] = '0;
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic rst_n; logic [3:0] req; logic [3:0] len0; logic up0; logic pause;
        logic [3:0] gnt; logic [3:0] done; logic busy; logic [3:0] cnt; logic zero; logic maxc;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] l, logic u, logic p,
                                logic [3:0] g, logic [3:0] d, logic b, logic [3:0] c,
                                logic z, logic m);
        vec_t v;
        v.rst_n = r; v.req = q; v.len0 = l; v.up0 = u; v.pause = p;
        v.gnt = g; v.done = d; v.busy = b; v.cnt = c; v.zero = z; v.maxc = m;
        return v;
    endfunction

    int done_at;
    bit seen_done;

    initial begin
        for (int i = 0; i < N; i++) lens[i] = '0;

        // Down-count of length 3 on requester 0, one row per clock.
        tbl[0] = mk(0, 4'b0000, 3, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
        tbl[1] = mk(1, 4'b0001, 3, 0, 0, 4'b0001, 4'b0000, 1, 0, 1, 0);
        tbl[2] = mk(1, 4'b0001, 3, 0, 0, 4'b0001, 4'b0000, 1, 3, 0, 0);
        tbl[3] = mk(1, 4'b0001, 3, 0, 0, 4'b0001, 4'b0000, 1, 2, 0, 0);
        tbl[4] = mk(1, 4'b0001, 3, 0, 0, 4'b0001, 4'b0000, 1, 1, 0, 0);
        tbl[5] = mk(1, 4'b0001, 3, 0, 0, 4'b0001, 4'b0000, 1, 0, 1, 0);
        tbl[6] = mk(1, 4'b0001, 3, 0, 0, 4'b0001, 4'b0001, 1, 0, 1, 0);
        tbl[7] = mk(1, 4'b0001, 3, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
        tbl[8] = mk(1, 4'b0000, 3, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
        for (int i = 0; i < 9; i++) begin
            rst_n = tbl[i].rst_n; req = tbl[i].req; lens[0] = tbl[i].len0;
            req_up = {3'b000, tbl[i].up0}; pause = tbl[i].pause;
            tick();
            chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(tbl[i].gnt));
            chk($sformatf("vec%0d.done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d.count", i), 32'(count_out), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.zero", i), 32'(zero), 32'(tbl[i].zero));
            chk($sformatf("vec%0d.max", i), 32'(max_count), 32'(tbl[i].maxc));
        end

        // All four requesting with zero length: strict rotation, one idle cycle between.
        hs_reset();
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            logic [3:0] e;
            e = 4'(1 << (g % 4));
            tick(); chk("rr.gnt_load", 32'(gnt), 32'(e)); chk("rr.nodone", 32'(done), 0);
            tick(); chk("rr.gnt_run", 32'(gnt), 32'(e));
            tick(); chk("rr.gnt_done", 32'(gnt), 32'(e)); chk("rr.done", 32'(done), 32'(e));
            tick(); chk("rr.idle_gap", 32'(gnt), 0);
        end

        // Full up-count with two paused RUN cycles.
        hs_reset();
        lens[0] = 4'd15; req_up = 4'b0001; req = 4'b0001; done_at = 0;
        for (int n = 1; n <= 21; n++) begin
            pause = (n == 8 || n == 9);
            tick();
            if (done[0] && done_at == 0) done_at = n;
            if (n == 2) chk("up.zero_at_start", 32'(zero), 1);
            if (n == 7) chk("up.count5", 32'(count_out), 5);
            if (n == 9) chk("up.paused_hold", 32'(count_out), 5);
            if (n == 18) chk("up.max_low", 32'(max_count), 0);
            if (n == 19) begin
                chk("up.count15", 32'(count_out), 15);
                chk("up.max_high", 32'(max_count), 1);
            end
        end
        pause = 1'b0;
        chk("up.done_latency", 32'(done_at), 20);

        // Abort by dropping the request mid-count.
        hs_reset();
        lens[2] = 4'd10; req_up = 4'b0100; req = 4'b0100; seen_done = 0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (done != 0) seen_done = 1;
        end
        chk("abort.count_before", 32'(count_out), 5);
        req = 4'b0000;
        tick();
        if (done != 0) seen_done = 1;
        chk("abort.gnt", 32'(gnt), 0);
        chk("abort.busy", 32'(busy), 0);
        chk("abort.count_held", 32'(count_out), 5);
        chk("abort.no_done", 32'(seen_done), 0);
        req = 4'b1011;
        tick();
        chk("abort.next_from_3", 32'(gnt), 32'(4'b1000));

        // Reset in the middle of a count.
        hs_reset();
        lens[1] = 4'd15; req_up = 4'b0010; req = 4'b0010;
        for (int n = 1; n <= 11; n++) tick();
        chk("rst.count9", 32'(count_out), 9);
        rst_n = 1'b0;
        tick();
        chk("rst.count", 32'(count_out), 0);
        chk("rst.gnt", 32'(gnt), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.zero", 32'(zero), 1);
        chk("rst.done", 32'(done), 0);
        rst_n = 1'b1; req = 4'b1111;
        tick();
        chk("rst.first_gnt", 32'(gnt), 32'(4'b0001));

        // Length change after the grant is ignored.
        hs_reset();
        lens[1] = 4'd4; req_up = 4'b0010; req = 4'b0010; done_at = 0;
        for (int n = 1; n <= 10; n++) begin
            if (n == 4) lens[1] = 4'd10;
            tick();
            if (done[1] && done_at == 0) begin
                done_at = n;
                chk("latch.count_at_done", 32'(count_out), 4);
            end
        end
        chk("latch.done_latency", 32'(done_at), 7);

        // Randomized traffic against the model.
        use_model = 1;
        hs_reset();
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] ed;
            ed = exp_onehot(m_fin);
            for (int i = 0; i < N; i++) begin
                if (!req[i]) begin
                    if ($urandom_range(5) == 0) begin
                        req[i] = 1'b1;
                        lens[i] = W'($urandom_range(15));
                        req_up[i] = 1'($urandom_range(1));
                    end
                end else if (ed[i]) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(39) == 0) begin
                    req[i] = 1'b0;
                end else if ($urandom_range(19) == 0) begin
                    lens[i] = W'($urandom_range(15));
                end
            end
            pause = ($urandom_range(3) == 0);
            rst_n = ($urandom_range(299) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
